// File: rtl/out_display_pkg.sv
// Shared types and constants for the 3-digit decimal output display.
package out_display_pkg;

  localparam int unsigned VALUE_W = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIG_N   = 3;
  localparam int unsigned ITER_W  = 3;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [IDX_W-1:0] DIG_ONES     = 2'd0;
  localparam logic [IDX_W-1:0] DIG_TENS     = 2'd1;
  localparam logic [IDX_W-1:0] DIG_HUNDREDS = 2'd2;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_display_seg7_decode.sv
// BCD nibble to active-high 7-segment pattern, with a blank override.
module seg7_decode
  import out_display_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/out_display.sv
// CPU output register to 3-digit multiplexed 7-segment display:
// sequential double-dabble conversion plus a refresh scanner.
module out_display
  import out_display_pkg::*;
#(
  parameter int unsigned REFRESH_BITS   = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  output logic [SEG_W-1:0]   seg,
  output logic               dp,
  output logic [DIG_N-1:0]   digit_en,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy
);

  state_t              state, state_next;
  logic [VALUE_W-1:0]  shreg, shreg_next;
  logic [BCD_W-1:0]    scratch, scratch_next, adjusted;
  logic [ITER_W-1:0]   iter, iter_next;
  logic [VALUE_W-1:0]  last_value, last_next;
  logic                valid, valid_next;
  logic [BCD_W-1:0]    bcd_next;
  logic                busy_next;

  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [IDX_W-1:0]        digit_idx, idx_next;

  logic [3:0]       nibble;
  logic             blank;
  logic [DIG_N-1:0] onehot;
  logic [SEG_W-1:0] pattern_c;

  // Conversion FSM: next state and datapath
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    scratch_next = scratch;
    iter_next    = iter;
    last_next    = last_value;
    valid_next   = valid;
    bcd_next     = bcd;
    busy_next    = busy;
    adjusted     = dabble_adjust(scratch);
    case (state)
      ST_IDLE: begin
        if (!valid || (value != last_value)) begin
          shreg_next   = value;
          scratch_next = '0;
          last_next    = value;
          valid_next   = 1'b1;
          busy_next    = 1'b1;
          iter_next    = '0;
          state_next   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {scratch_next, shreg_next} = {adjusted, shreg} << 1;
        iter_next = iter + ITER_W'(1);
        if (iter == ITER_W'(7)) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        bcd_next   = scratch;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Digit scan: advance on refresh wrap, recover from the unused index
  always_comb begin
    idx_next = digit_idx;
    if (&refresh_cnt) begin
      case (digit_idx)
        DIG_ONES: idx_next = DIG_TENS;
        DIG_TENS: idx_next = DIG_HUNDREDS;
        default:  idx_next = DIG_ONES;
      endcase
    end else if (digit_idx == IDX_W'(3)) begin
      idx_next = DIG_ONES;
    end
  end

  // Digit select with leading-zero blanking from the committed bcd
  always_comb begin
    nibble = bcd[3:0];
    blank  = 1'b0;
    onehot = 3'b001;
    case (digit_idx)
      DIG_TENS: begin
        nibble = bcd[7:4];
        blank  = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        onehot = 3'b010;
      end
      DIG_HUNDREDS: begin
        nibble = bcd[11:8];
        blank  = (bcd[11:8] == 4'd0);
        onehot = 3'b100;
      end
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .blank  (blank),
    .seg_c  (pattern_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      scratch     <= '0;
      iter        <= '0;
      last_value  <= '0;
      valid       <= 1'b0;
      bcd         <= '0;
      busy        <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= DIG_ONES;
      seg         <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
      dp          <= SEG_ACTIVE_LOW;
      digit_en    <= DIG_ACTIVE_LOW ? ~3'b001 : 3'b001;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      scratch     <= scratch_next;
      iter        <= iter_next;
      last_value  <= last_next;
      valid       <= valid_next;
      bcd         <= bcd_next;
      busy        <= busy_next;
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      digit_idx   <= idx_next;
      seg         <= SEG_ACTIVE_LOW ? ~pattern_c : pattern_c;
      dp          <= SEG_ACTIVE_LOW;
      digit_en    <= DIG_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: conversion latency, display pins, corner sequences.
module tb_out_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] value = 8'd0;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] digit_en;
  logic [11:0] bcd;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Pin-level (active-low) segment expectations
  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000,
                         P9 = 7'b0010000, PB = 7'b1111111;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] exp_bcd;
    logic [6:0]  po, pt, ph;
  } vec_t;

  vec_t vecs [8];

  out_display dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .seg      (seg),
    .dp       (dp),
    .digit_en (digit_en),
    .bcd      (bcd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_conv(input logic [11:0] exp_bcd, input string tag);
    int wait_c = 0;
    int len = 0;
    while (!busy && wait_c < 20) begin tick(); wait_c++; end
    check({tag, " busy rise"}, 32'(busy), 32'd1);
    while (busy && len < 20) begin tick(); len++; end
    check({tag, " busy len"}, 32'(len), 32'd9);
    check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
  endtask

  task automatic check_display(input logic [6:0] po, input logic [6:0] pt,
                               input logic [6:0] ph, input string tag);
    bit seen [3];
    bit bad  [3];
    bit nonhot;
    for (int k = 0; k < 3; k++) begin seen[k] = 1'b0; bad[k] = 1'b0; end
    nonhot = 1'b0;
    for (int c = 0; c < 49; c++) begin
      tick();
      case (digit_en)
        3'b110: begin seen[0] = 1'b1; if (seg !== po) bad[0] = 1'b1; end
        3'b101: begin seen[1] = 1'b1; if (seg !== pt) bad[1] = 1'b1; end
        3'b011: begin seen[2] = 1'b1; if (seg !== ph) bad[2] = 1'b1; end
        default: nonhot = 1'b1;
      endcase
      if (dp !== 1'b1) nonhot = 1'b1;
    end
    check({tag, " ones seen/bad"}, {30'd0, seen[0], bad[0]}, 32'd2);
    check({tag, " tens seen/bad"}, {30'd0, seen[1], bad[1]}, 32'd2);
    check({tag, " hund seen/bad"}, {30'd0, seen[2], bad[2]}, 32'd2);
    check({tag, " onehot/dp"}, 32'(nonhot), 32'd0);
  endtask

  initial begin
    int pulses, len0, len1, gap, wait_c, sweep_err, nonhot, prev;
    logic prev_busy;
    logic [11:0] bcd_first, exp;
    bit saw200;

    vecs[0] = '{8'd255, 12'h255, P5, P5, P2};
    vecs[1] = '{8'd7,   12'h007, P7, PB, PB};
    vecs[2] = '{8'd100, 12'h100, P0, P0, P1};
    vecs[3] = '{8'd0,   12'h000, P0, PB, PB};
    vecs[4] = '{8'd99,  12'h099, P9, P9, PB};
    vecs[5] = '{8'd208, 12'h208, P8, P0, P2};
    vecs[6] = '{8'd43,  12'h043, P3, P4, PB};
    vecs[7] = '{8'd16,  12'h016, P6, P1, PB};

    // Reset state with 255 held on the input
    reset = 1'b0;
    value = 8'd255;
    repeat (2) tick();
    check("reset bcd", 32'(bcd), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset digit_en", 32'(digit_en), 32'b110);
    check("reset seg", 32'(seg), 32'(P0));
    check("reset dp", 32'(dp), 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      value = vecs[i].val;
      run_conv(vecs[i].exp_bcd, $sformatf("vec%0d", i));
      check_display(vecs[i].po, vecs[i].pt, vecs[i].ph, $sformatf("vec%0d", i));
    end

    // Value changes while busy: 10 commits, then only the latest (55)
    value = 8'd10;
    pulses = 0; len0 = 0; len1 = 0; gap = 0;
    prev_busy = 1'b0; bcd_first = '0; saw200 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy) begin
        if (!prev_busy) pulses++;
        if (pulses == 1) len0++;
        else if (pulses == 2) len1++;
      end else begin
        if (prev_busy && pulses == 1) bcd_first = bcd;
        if (pulses == 1) gap++;
      end
      if (bcd == 12'h200) saw200 = 1'b1;
      prev_busy = busy;
      if (c == 2) value = 8'd200;
      if (c == 5) value = 8'd55;
    end
    check("busy pulses", 32'(pulses), 32'd2);
    check("pulse1 len", 32'(len0), 32'd9);
    check("pulse2 len", 32'(len1), 32'd9);
    check("idle gap >=1", 32'(gap >= 1), 32'd1);
    check("first commit", 32'(bcd_first), 32'h010);
    check("final commit", 32'(bcd), 32'h055);
    check("200 never shown", 32'(saw200), 32'd0);

    // Reset on the 4th CONVERT edge of a 128 conversion
    value = 8'd128;
    wait_c = 0;
    while (!busy && wait_c < 20) begin tick(); wait_c++; end
    check("128 busy rise", 32'(busy), 32'd1);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("midreset bcd", 32'(bcd), 32'h0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset digit_en", 32'(digit_en), 32'b110);
    reset = 1'b1;
    run_conv(12'h128, "reconv128");
    check_display(P8, P2, P1, "disp128");

    // Exhaustive sweep 0..255
    prev = 128;
    sweep_err = 0;
    nonhot = 0;
    for (int v = 0; v < 256; v++) begin
      value = 8'(v);
      exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      if (v != prev) begin
        wait_c = 0;
        while (!busy && wait_c < 20) begin tick(); wait_c++; end
        if (!busy) sweep_err++;
        wait_c = 0;
        while (busy && wait_c < 20) begin
          tick(); wait_c++;
          if (!(digit_en == 3'b110 || digit_en == 3'b101 || digit_en == 3'b011)) nonhot++;
        end
        if (wait_c != 9) sweep_err++;
      end
      if (bcd !== exp) begin
        sweep_err++;
        if (sweep_err < 5) $display("FAIL sweep v=%0d: bcd got %0h, expected %0h", v, bcd, exp);
      end
      prev = v;
    end
    check("sweep errors", 32'(sweep_err), 32'd0);
    check("sweep onehot", 32'(nonhot), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/out_display.md
Name: out_display

Overview:
- Downstream consumer of the CPU's 8-bit output register on the board top level; replaces the raw 8-LED binary display.
- Converts the unsigned output value to 3 decimal digits with a sequential double-dabble engine, then time-multiplexes them onto a 3-digit common-anode 7-segment display.
- Runs in the divided CPU clock domain, the same clock that drives the CPU.

Parameters:
- REFRESH_BITS, 4: width of the refresh counter; the active digit advances each time the counter wraps from all-ones to 0.
- SEG_ACTIVE_LOW, 1: 1 inverts seg/dp at the pins; 0 drives them active-high.
- DIG_ACTIVE_LOW, 1: 1 inverts digit_en at the pins; 0 drives it active-high.

Ports:
- clk, in, 1: CPU clock (divided board clock); all logic on rising edge.
- reset, in, 1: synchronous, active-low; 0 on a rising edge resets the block.
- value, in, 8: CPU output register, unsigned 0..255, sampled every cycle.
- seg, out, 7: {g,f,e,d,c,b,a} for the currently enabled digit.
- dp, out, 1: decimal point, always off.
- digit_en, out, 3: one-hot digit enable; bit0 = ones, bit1 = tens, bit2 = hundreds.
- bcd, out, 12: {hundreds,tens,ones} of the last committed value.
- busy, out, 1: high while a conversion is in flight.

Behaviour:
- Reset (reset=0 at an edge):
  - bcd=0, busy=0, state=IDLE, refresh counter=0, digit index=0.
  - last_value=0, valid=0.
  - Pin-level result: digit_en selects ones, seg shows "0".
- FSM states:
  - IDLE:
    - If valid=0 or value!=last_value, this edge is E0: capture value into the shift register, clear the BCD scratch, set last_value=value, valid=1, busy=1, iter=0, go to CONVERT.
    - Otherwise hold.
  - CONVERT, edges E1..E8, one iteration per edge:
    - Each BCD nibble >=5 gets +3 first, then {scratch,shreg} shifts left by 1.
    - Scratch is 12 bits; no carry beyond bit 11 is possible for 8-bit input.
    - iter increments; after the 8th iteration go to COMMIT.
  - COMMIT, edge E9: bcd<=scratch, busy<=0, go to IDLE.
- Latency and input changes:
  - Fixed latency: busy is high for exactly 9 cycles; bcd is visible after E9.
  - value changes during CONVERT/COMMIT are ignored. IDLE compares against last_value (the captured value), so the newest value converts on the edge after COMMIT. Intermediate values may be skipped; the final value is never lost.
  - A value that toggles and returns to last_value while busy causes no reconversion.
- Refresh:
  - The counter increments every cycle regardless of FSM state.
  - On wrap, digit index goes 0→1→2→0.
  - Index 3 is unreachable; if ever reached, force it to 0.
- Display:
  - Display always shows the committed bcd, never the scratch.
  - Leading-zero blanking: hundreds blanked if 0; tens blanked if hundreds=0 and tens=0; ones never blanked.
  - A blanked digit keeps digit_en asserted with seg all off.
- Segment patterns (active-high, before polarity inversion):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Nibbles >9 are unreachable; decode them as all off.
- Output timing: seg, dp and digit_en are registered (one cycle after the index/bcd change), so there is no glitching between digits.
- Reset mid-conversion: the conversion is abandoned, bcd returns to 0, and value is reconverted after release (valid=0).

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, CONVERT, COMMIT).
  - The 10 segment pattern constants plus SEG_BLANK.
  - Digit index constants (DIG_ONES, DIG_TENS, DIG_HUNDREDS).
- One combinational sub-module, seg7_decode: 4-bit nibble plus blank flag in, 7-bit active-high pattern out. Instantiate it once, muxed by digit index.
- Double-dabble engine and refresh logic stay in out_display.

Test Plan:
1. Reset, then release with value=255 held: busy rises at E0, stays high 9 cycles, then bcd=0x255. Over 3 refresh periods (REFRESH_BITS=4, 16 cycles each), pins show digit ones→"5" (seg pins 0010010), tens→"5", hundreds→"2" (0100100).
2. value=7 after idle: bcd=0x007. Hundreds and tens slots have all seg pins high (blank); ones shows "7" (1111000).
3. value=100 then 0: bcd=0x100 with tens shown as "0" (not blanked). Then bcd=0x000 with only ones lit "0".
4. value changes 10→200→55 while busy after 10 is captured: 10 commits, then exactly one further conversion commits 55. bcd never shows 200; busy shows two 9-cycle pulses separated by ≥1 idle cycle.
5. Assert reset on the 4th CONVERT cycle of a 128 conversion: next edge gives bcd=0, busy=0, digit_en=ones. After release, 128 reconverts and commits bcd=0x128 9 cycles after E0.
6. Exhaustive sweep of 0..255, each held until busy falls: bcd equals the decimal digits of every value, and digit_en is always one-hot.
